fht_input_loader: RTL
=====================

Name: fht_input_loader

Overview:
- Upstream neighbour of fht_control: accepts a stream of N real time-domain samples over a valid/ready handshake.
- Writes each sample into the 4 data RAM banks at its bit-reversed position, so stage 0 of the FHT reads in natural order.
- After the last sample of a frame, pulses the FHT start request and holds off new input until fht_control reports ready again.

Parameters:
- N_BIT, 10, log2 of transform length (N = 1024).
- A_BIT, 8, bank address width; always N_BIT-2 (4 banks).
- D_BIT, 16, sample width.

Ports:
- iCLK  in  1  clock
- iRESET  in  1  reset
- iDATA  in  D_BIT  input sample
- iVALID  in  1  sample valid
- oREADY  out  1  loader accepts a sample this cycle
- oDATA_WR  out  D_BIT  data to bank write port
- oADDR_WR  out  A_BIT  bank write address
- oWE  out  4  one-hot bank write enable (bit b = bank b)
- oFHT_START  out  1  one-cycle start pulse, drives fht_control iSTART
- iFHT_RDY  in  1  fht_control oRDY
- oBUSY  out  1  high from frame-complete until FHT done

Interface rule:
- One clock; reset is synchronous and active-high.
- Clock port is iCLK, reset port is iRESET.

Behaviour:
- Reset (iRESET=1 at iCLK edge):
  - State = LOAD; sample index k = 0.
  - oREADY=1, oWE=0, oDATA_WR=0, oADDR_WR=0, oFHT_START=0, oBUSY=0.
  - Reset mid-frame discards the partial frame; no start pulse is issued.
- Accept condition: iVALID & oREADY.
- On accept, with r = bit-reverse of k over N_BIT bits:
  - bank = r[1:0]; address = r[N_BIT-1:2].
  - Next cycle: oWE[bank]=1, oADDR_WR=address, oDATA_WR=iDATA. Latency is 1 cycle, registered.
  - oWE is 0 in every cycle without an accept.
- k increments per accept. k = N-1 accepted → k wraps to 0 and state → START.
- iVALID while oREADY=0: ignored; no write and no index change.
- States:
  - LOAD: oREADY=1. Leave on the accept of k = N-1.
  - START: oREADY=0, oBUSY=1. Held until the final write has been issued (the cycle after the last accept). oFHT_START=1 for exactly that one cycle, then → WAIT_BUSY.
  - WAIT_BUSY: oREADY=0, oBUSY=1. Wait for iFHT_RDY=0, then → WAIT_DONE.
    - Guards against fht_control's rdy being high before it registers the start.
    - If iFHT_RDY stays 1 for 4 cycles, re-issue oFHT_START once and remain in WAIT_BUSY.
  - WAIT_DONE: oREADY=0, oBUSY=1. On iFHT_RDY=1 → LOAD, with oREADY=1 the next cycle.
- Bit-reverse is purely combinational over the N_BIT-bit index; no arithmetic overflow is possible.
- Throughput: 1 sample/cycle in LOAD; at most one bank written per cycle.

Optional Feature:
- Macro: FHT_LOADER_SOF_EN.
- Enabled:
  - Adds port iSOF (in, 1), qualified by accept, and port oSOF_ERR (out, 1, one-cycle pulse).
  - Accept with iSOF=1 forces the sample to k=0: it is written at k=0 and k becomes 1.
  - oSOF_ERR pulses if iSOF=1 arrives with k≠0 (partial frame discarded, load restarts).
  - oSOF_ERR also pulses if k=0 is accepted with iSOF=0; that sample is dropped (no write).
  - oSOF_ERR reset value is 0.
- Disabled: no iSOF/oSOF_ERR ports; framing is purely by count.

Decomposition:
- Shared package fht_pkg:
  - N_BIT, A_BIT, D_BIT, N_BANK=4.
  - Loader state encoding: LOAD, START, WAIT_BUSY, WAIT_DONE.
  - Bit-reverse function, reusable by the output unloader.
- One natural sub-module: fht_bitrev_addr. Combinational k → {address, bank one-hot}; parameterised by N_BIT.

Test Plan:
- Reset, then k=0 accepted → next cycle oWE=4'b0001, oADDR_WR=0. k=1 → oWE=4'b0001, oADDR_WR=128. k=3 → oADDR_WR=192.
- k=256 → oWE=4'b0100, oADDR_WR=0. k=1023 → oWE=4'b1000, oADDR_WR=255.
- Stream 1024 samples back-to-back → oREADY falls after the 1024th accept, then a single oFHT_START pulse. Model iFHT_RDY low 20 cycles then high → oREADY=1 the cycle after iFHT_RDY rises. No write occurs while iVALID is held 1 during wait.
- iVALID toggled 1/0 every cycle for a frame → exactly 1024 writes, each of the 1024 bank/address pairs written once.
- iRESET asserted at k=500 → no oFHT_START, oWE=0. Next frame starts at k=0 (oADDR_WR=0, bank 0).
- With FHT_LOADER_SOF_EN: iSOF=1 at k=10 → oSOF_ERR pulse, sample written at addr 0 bank 0, k=1. Frame start with iSOF=0 → oSOF_ERR pulse, no write.

Source files
------------

// File: rtl/fht_pkg.sv
// Shared definitions for the FHT datapath: sizes, loader state encoding and
// the bit-reverse helper (also reused by the output unloader).
package fht_pkg;

  localparam int N_BIT  = 10;
  localparam int A_BIT  = N_BIT - 2;
  localparam int D_BIT  = 16;
  localparam int N_BANK = 4;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } ld_state_e;

  function automatic logic [N_BIT-1:0] bitrev(input logic [N_BIT-1:0] k);
    logic [N_BIT-1:0] r;
    for (int i = 0; i < N_BIT; i++) r[i] = k[N_BIT-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fht_bitrev_addr.sv
// Maps a natural-order sample index to its bit-reversed bank/address pair:
// the two low bits of the reversed index pick the bank, the rest address it.
module fht_bitrev_addr #(
  parameter int N_BIT = fht_pkg::N_BIT
) (
  input  logic [N_BIT-1:0]          idx_i,
  output logic [N_BIT-3:0]          addr_o,
  output logic [fht_pkg::N_BANK-1:0] bank_oh_o
);

  logic [N_BIT-1:0] rev;

  always_comb begin
    for (int i = 0; i < N_BIT; i++) rev[i] = idx_i[N_BIT-1-i];
  end

  assign addr_o = rev[N_BIT-1:2];

  always_comb begin
    bank_oh_o           = '0;
    bank_oh_o[rev[1:0]] = 1'b1;
  end

endmodule

// File: rtl/fht_input_loader.sv
// Streams N samples into the four FHT data banks in bit-reversed order, then
// kicks fht_control and blocks input until it finishes.
// Optional start-of-frame framing: define FHT_LOADER_SOF_EN.
module fht_input_loader #(
  parameter int N_BIT = fht_pkg::N_BIT,
  parameter int A_BIT = fht_pkg::A_BIT,
  parameter int D_BIT = fht_pkg::D_BIT
) (
  input  logic                        iCLK,
  input  logic                        iRESET,
  input  logic [D_BIT-1:0]            iDATA,
  input  logic                        iVALID,
  output logic                        oREADY,
  output logic [D_BIT-1:0]            oDATA_WR,
  output logic [A_BIT-1:0]            oADDR_WR,
  output logic [fht_pkg::N_BANK-1:0]  oWE,
  output logic                        oFHT_START,
  input  logic                        iFHT_RDY,
  output logic                        oBUSY
`ifdef FHT_LOADER_SOF_EN
  ,
  input  logic                        iSOF,
  output logic                        oSOF_ERR
`endif
);

  import fht_pkg::*;

  ld_state_e           state_q, state_d;
  logic [N_BIT-1:0]    k_q, k_d;
  logic [1:0]          hold_cnt_q, hold_cnt_d;
  logic                reissued_q, reissued_d;
  logic                restart_q, restart_d;
  logic [N_BANK-1:0]   we_q, we_d;
  logic [A_BIT-1:0]    addr_q, addr_d;
  logic [D_BIT-1:0]    data_q, data_d;

  logic                accept;
  logic                do_write;
  logic [N_BIT-1:0]    idx;
  logic [A_BIT-1:0]    br_addr;
  logic [N_BANK-1:0]   br_bank;

  assign accept = iVALID & (state_q == LOAD);

`ifdef FHT_LOADER_SOF_EN
  logic sof_err_q, sof_err_d;

  // SOF pins the sample to slot 0; a slot-0 sample without SOF is dropped.
  always_comb begin
    idx       = iSOF ? '0 : k_q;
    do_write  = accept & (iSOF | (k_q != '0));
    sof_err_d = accept & (iSOF ? (k_q != '0) : (k_q == '0));
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) sof_err_q <= 1'b0;
    else        sof_err_q <= sof_err_d;
  end

  assign oSOF_ERR = sof_err_q;
`else
  always_comb begin
    idx      = k_q;
    do_write = accept;
  end
`endif

  fht_bitrev_addr #(.N_BIT(N_BIT)) u_bitrev (
    .idx_i     (idx),
    .addr_o    (br_addr),
    .bank_oh_o (br_bank)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    hold_cnt_d = hold_cnt_q;
    reissued_d = reissued_q;
    restart_d  = 1'b0;
    we_d       = '0;
    addr_d     = addr_q;
    data_d     = data_q;

    if (do_write) begin
      we_d   = br_bank;
      addr_d = br_addr;
      data_d = iDATA;
    end

    case (state_q)
      LOAD: begin
        if (do_write) begin
          if (&idx) begin
            k_d     = '0;
            state_d = START;
          end else begin
            k_d = idx + 1'b1;
          end
        end
      end
      START: begin
        state_d    = WAIT_BUSY;
        hold_cnt_d = '0;
        reissued_d = 1'b0;
      end
      WAIT_BUSY: begin
        // fht_control may still show ready before it latches the start;
        // if it never drops, nudge it with one more start pulse.
        if (!iFHT_RDY) begin
          state_d = WAIT_DONE;
        end else if (!reissued_q) begin
          if (hold_cnt_q == 2'd3) begin
            restart_d  = 1'b1;
            reissued_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      WAIT_DONE: begin
        if (iFHT_RDY) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= LOAD;
      k_q        <= '0;
      hold_cnt_q <= '0;
      reissued_q <= 1'b0;
      restart_q  <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      hold_cnt_q <= hold_cnt_d;
      reissued_q <= reissued_d;
      restart_q  <= restart_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign oREADY     = (state_q == LOAD);
  assign oBUSY      = (state_q != LOAD);
  assign oFHT_START = (state_q == START) | restart_q;
  assign oWE        = we_q;
  assign oADDR_WR   = addr_q;
  assign oDATA_WR   = data_q;

endmodule
